// File: rtl/ascon_ctrl_fsm.sv
// Moore control FSM for the ASCON AEAD datapath with parametrised round counts,
// valid/ready block handshake, optional AD phase and encrypt/decrypt mode.
module ascon_ctrl_fsm #(
  parameter int unsigned ROUNDS_A    = 12,
  parameter int unsigned ROUNDS_B    = 6,
  parameter int unsigned BLOCK_CNT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_sys_enable,
  input  logic                   i_start,
  input  logic                   i_decrypt,
  input  logic                   i_skip_ad,
  input  logic                   i_data_valid,
  input  logic                   i_last_block,
  output logic                   o_data_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_mux_select,
  output logic                   o_enable_state_reg,
  output logic                   o_enable_xor_data_begin,
  output logic                   o_enable_xor_key_begin,
  output logic                   o_enable_xor_key_end,
  output logic                   o_enable_xor_lsb_end,
  output logic                   o_replace_state,
  output logic                   o_enable_cipher_reg,
  output logic                   o_valid_cipher,
  output logic                   o_enable_tag_reg,
  output logic [3:0]             o_round_index,
  output logic [BLOCK_CNT_W-1:0] o_block_count
);

  localparam logic [3:0] StIdle        = 4'd0;
  localparam logic [3:0] StLoad        = 4'd1;
  localparam logic [3:0] StInitRounds  = 4'd2;
  localparam logic [3:0] StAdWait      = 4'd3;
  localparam logic [3:0] StAdRounds    = 4'd4;
  localparam logic [3:0] StDataWait    = 4'd5;
  localparam logic [3:0] StDataRounds  = 4'd6;
  localparam logic [3:0] StFinalRounds = 4'd7;
  localparam logic [3:0] StDone        = 4'd8;

  // Counters run up to 11 so the index doubles as the round-constant index.
  localparam logic [3:0] RndStartA = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RndStartB = 4'(12 - ROUNDS_B);
  localparam logic [3:0] RndLast   = 4'd11;
  localparam logic [BLOCK_CNT_W-1:0] BlkMax = '1;

  logic [3:0]             r_state, w_state_next;
  logic [3:0]             r_round, w_round_next;
  logic [BLOCK_CNT_W-1:0] r_blk_cnt, w_blk_cnt_next;
  logic                   r_decrypt, w_decrypt_next;
  logic                   r_skip_ad, w_skip_ad_next;
  logic                   r_last, w_last_next;

  logic w_ready;
  logic w_accept;
  logic w_first_a;
  logic w_first_b;
  logic w_round_last;

  assign w_ready      = (r_state == StAdWait) || (r_state == StDataWait);
  assign w_accept     = i_data_valid && w_ready;
  assign w_first_a    = (r_round == RndStartA);
  assign w_first_b    = (r_round == RndStartB);
  assign w_round_last = (r_round == RndLast);

  always_comb begin
    w_state_next   = r_state;
    w_round_next   = r_round;
    w_blk_cnt_next = r_blk_cnt;
    w_decrypt_next = r_decrypt;
    w_skip_ad_next = r_skip_ad;
    w_last_next    = r_last;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next   = StLoad;
          w_decrypt_next = i_decrypt;
          w_skip_ad_next = i_skip_ad;
          w_blk_cnt_next = '0;
          w_last_next    = 1'b0;
          w_round_next   = 4'd0;
        end
      end
      StLoad: begin
        w_state_next = StInitRounds;
        w_round_next = RndStartA;
      end
      StInitRounds: begin
        if (w_round_last) begin
          w_round_next = 4'd0;
          w_state_next = r_skip_ad ? StDataWait : StAdWait;
        end else begin
          w_round_next = r_round + 4'd1;
        end
      end
      StAdWait: begin
        if (w_accept) begin
          w_last_next  = i_last_block;
          w_round_next = RndStartB;
          w_state_next = StAdRounds;
        end
      end
      StAdRounds: begin
        if (w_round_last) begin
          w_round_next = 4'd0;
          w_state_next = r_last ? StDataWait : StAdWait;
        end else begin
          w_round_next = r_round + 4'd1;
        end
      end
      StDataWait: begin
        if (w_accept) begin
          w_last_next = i_last_block;
          if (r_blk_cnt != BlkMax) w_blk_cnt_next = r_blk_cnt + 1'b1;
          if (i_last_block) begin
            w_round_next = RndStartA;
            w_state_next = StFinalRounds;
          end else begin
            w_round_next = RndStartB;
            w_state_next = StDataRounds;
          end
        end
      end
      StDataRounds: begin
        if (w_round_last) begin
          w_round_next = 4'd0;
          w_state_next = StDataWait;
        end else begin
          w_round_next = r_round + 4'd1;
        end
      end
      StFinalRounds: begin
        if (w_round_last) begin
          w_round_next = 4'd0;
          w_state_next = StDone;
        end else begin
          w_round_next = r_round + 4'd1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
        w_round_next = 4'd0;
      end
    endcase
  end

  // Disable acts exactly like reset so an abort never leaves a partial operation.
  always_ff @(posedge clock) begin
    if (!reset_n || !i_sys_enable) begin
      r_state   <= StIdle;
      r_round   <= 4'd0;
      r_blk_cnt <= '0;
      r_decrypt <= 1'b0;
      r_skip_ad <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_round   <= w_round_next;
      r_blk_cnt <= w_blk_cnt_next;
      r_decrypt <= w_decrypt_next;
      r_skip_ad <= w_skip_ad_next;
      r_last    <= w_last_next;
    end
  end

  always_comb begin
    o_mux_select            = 1'b1;
    o_enable_state_reg      = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_replace_state         = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_valid_cipher          = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_done                  = 1'b0;
    case (r_state)
      StLoad: begin
        o_mux_select       = 1'b0;
        o_enable_state_reg = 1'b1;
      end
      StInitRounds: begin
        o_enable_state_reg = 1'b1;
        if (w_round_last) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_xor_lsb_end = r_skip_ad;
        end
      end
      StAdRounds: begin
        o_enable_state_reg      = 1'b1;
        o_enable_xor_data_begin = w_first_b;
        o_enable_xor_lsb_end    = w_round_last && r_last;
      end
      StDataRounds: begin
        o_enable_state_reg = 1'b1;
        if (w_first_b) begin
          o_enable_xor_data_begin = 1'b1;
          o_enable_cipher_reg     = 1'b1;
          o_valid_cipher          = 1'b1;
          o_replace_state         = r_decrypt;
        end
      end
      StFinalRounds: begin
        o_enable_state_reg = 1'b1;
        if (w_first_a) begin
          o_enable_xor_data_begin = 1'b1;
          o_enable_xor_key_begin  = 1'b1;
          o_enable_cipher_reg     = 1'b1;
          o_valid_cipher          = 1'b1;
          o_replace_state         = r_decrypt;
        end
        if (w_round_last) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_tag_reg     = 1'b1;
        end
      end
      StDone: begin
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_data_ready  = w_ready;
  assign o_busy        = (r_state != StIdle);
  assign o_round_index = r_round;
  assign o_block_count = r_blk_cnt;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: dut0 is ASCON-128 (12/6, 4-bit count),
// dut1 is ASCON-128a (12/8) with a 2-bit block counter to exercise saturation.
module tb_ascon_ctrl_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstn [2];
  logic sys_en [2];
  logic start [2];
  logic dec [2];
  logic skip [2];
  logic valid [2];
  logic last [2];

  wire ready [2];
  wire busy [2];
  wire done [2];
  wire mux [2];
  wire en_state [2];
  wire xdb [2];
  wire xkb [2];
  wire xke [2];
  wire xle [2];
  wire repl [2];
  wire en_cipher [2];
  wire vcipher [2];
  wire en_tag [2];
  wire [3:0] ridx [2];
  wire [3:0] bcnt0;
  wire [1:0] bcnt1;

  int n_cmp = 0;
  int n_err = 0;

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6), .BLOCK_CNT_W(4)) dut0 (
    .clock(clock), .reset_n(rstn[0]), .i_sys_enable(sys_en[0]), .i_start(start[0]),
    .i_decrypt(dec[0]), .i_skip_ad(skip[0]), .i_data_valid(valid[0]),
    .i_last_block(last[0]), .o_data_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_mux_select(mux[0]), .o_enable_state_reg(en_state[0]),
    .o_enable_xor_data_begin(xdb[0]), .o_enable_xor_key_begin(xkb[0]),
    .o_enable_xor_key_end(xke[0]), .o_enable_xor_lsb_end(xle[0]),
    .o_replace_state(repl[0]), .o_enable_cipher_reg(en_cipher[0]),
    .o_valid_cipher(vcipher[0]), .o_enable_tag_reg(en_tag[0]),
    .o_round_index(ridx[0]), .o_block_count(bcnt0)
  );

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(8), .BLOCK_CNT_W(2)) dut1 (
    .clock(clock), .reset_n(rstn[1]), .i_sys_enable(sys_en[1]), .i_start(start[1]),
    .i_decrypt(dec[1]), .i_skip_ad(skip[1]), .i_data_valid(valid[1]),
    .i_last_block(last[1]), .o_data_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_mux_select(mux[1]), .o_enable_state_reg(en_state[1]),
    .o_enable_xor_data_begin(xdb[1]), .o_enable_xor_key_begin(xkb[1]),
    .o_enable_xor_key_end(xke[1]), .o_enable_xor_lsb_end(xle[1]),
    .o_replace_state(repl[1]), .o_enable_cipher_reg(en_cipher[1]),
    .o_valid_cipher(vcipher[1]), .o_enable_tag_reg(en_tag[1]),
    .o_round_index(ridx[1]), .o_block_count(bcnt1)
  );

  function automatic logic [3:0] bcnt(input int d);
    return (d == 0) ? bcnt0 : {2'b00, bcnt1};
  endfunction

  task automatic check_eq(input string tag, input int d, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", tag, d, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input int d);
    check_eq("idle_busy", d, busy[d], 0);
    check_eq("idle_mux", d, mux[d], 1);
    check_eq("idle_ready", d, ready[d], 0);
    check_eq("idle_en_state", d, en_state[d], 0);
    check_eq("idle_done", d, done[d], 0);
    check_eq("idle_ridx", d, ridx[d], 0);
    check_eq("idle_bcnt", d, bcnt(d), 0);
    check_eq("idle_tag", d, en_tag[d], 0);
    check_eq("idle_vcipher", d, vcipher[d], 0);
  endtask

  // Leaves the DUT on the first INIT_ROUNDS cycle.
  task automatic do_start(input int d, input logic m_dec, input logic m_skip);
    start[d] = 1'b1;
    dec[d]   = m_dec;
    skip[d]  = m_skip;
    tick();
    check_eq("load_mux", d, mux[d], 0);
    check_eq("load_en_state", d, en_state[d], 1);
    check_eq("load_busy", d, busy[d], 1);
    start[d] = 1'b0;
    dec[d]   = 1'b0;
    skip[d]  = 1'b0;
    tick();
  endtask

  task automatic init_rounds(input int d, input logic m_skip);
    for (int i = 0; i < 12; i++) begin
      check_eq("init_ridx", d, ridx[d], i);
      check_eq("init_en_state", d, en_state[d], 1);
      check_eq("init_xke", d, xke[d], (i == 11));
      check_eq("init_xle", d, xle[d], (m_skip && i == 11));
      check_eq("init_ready", d, ready[d], 0);
      tick();
    end
  endtask

  task automatic accept(input int d, input logic m_last);
    check_eq("wait_ready", d, ready[d], 1);
    check_eq("wait_en_state", d, en_state[d], 0);
    valid[d] = 1'b1;
    last[d]  = m_last;
    tick();
    valid[d] = 1'b0;
    last[d]  = 1'b0;
  endtask

  task automatic ad_rounds(input int d, input int rb, input logic m_last);
    for (int i = 12 - rb; i < 12; i++) begin
      check_eq("ad_ridx", d, ridx[d], i);
      check_eq("ad_xdb", d, xdb[d], (i == 12 - rb));
      check_eq("ad_xle", d, xle[d], (m_last && i == 11));
      check_eq("ad_vcipher", d, vcipher[d], 0);
      tick();
    end
  endtask

  task automatic data_rounds(input int d, input int rb, input logic m_dec, input int exp_cnt,
                             input logic hold_valid);
    if (hold_valid) valid[d] = 1'b1;
    for (int i = 12 - rb; i < 12; i++) begin
      check_eq("data_ridx", d, ridx[d], i);
      check_eq("data_ready", d, ready[d], 0);
      check_eq("data_vcipher", d, vcipher[d], (i == 12 - rb));
      check_eq("data_en_cipher", d, en_cipher[d], (i == 12 - rb));
      check_eq("data_xdb", d, xdb[d], (i == 12 - rb));
      check_eq("data_repl", d, repl[d], (m_dec && i == 12 - rb));
      check_eq("data_bcnt", d, bcnt(d), exp_cnt);
      tick();
    end
    valid[d] = 1'b0;
  endtask

  task automatic final_rounds(input int d, input logic m_dec, input int exp_cnt);
    for (int i = 0; i < 12; i++) begin
      check_eq("fin_ridx", d, ridx[d], i);
      check_eq("fin_xdb", d, xdb[d], (i == 0));
      check_eq("fin_xkb", d, xkb[d], (i == 0));
      check_eq("fin_vcipher", d, vcipher[d], (i == 0));
      check_eq("fin_repl", d, repl[d], (m_dec && i == 0));
      check_eq("fin_xke", d, xke[d], (i == 11));
      check_eq("fin_tag", d, en_tag[d], (i == 11));
      check_eq("fin_done", d, done[d], 0);
      check_eq("fin_bcnt", d, bcnt(d), exp_cnt);
      tick();
    end
  endtask

  // A start raised during DONE must be ignored: DUT stays idle afterwards.
  task automatic check_done(input int d, input int exp_cnt);
    check_eq("done_pulse", d, done[d], 1);
    check_eq("done_busy", d, busy[d], 1);
    check_eq("done_en_state", d, en_state[d], 0);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check_eq("post_done", d, done[d], 0);
    check_eq("post_busy", d, busy[d], 0);
    check_eq("post_bcnt", d, bcnt(d), exp_cnt);
    tick();
    check_eq("restart_ignored", d, busy[d], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; sys_en[d] = 1'b1; start[d] = 1'b0; dec[d] = 1'b0;
      skip[d] = 1'b0; valid[d] = 1'b0; last[d] = 1'b0;
    end
    tick();
    tick();
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    check_idle(0);
    check_idle(1);

    // Valid with no ready in IDLE has no effect.
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    check_idle(0);

    // dut0 encrypt: one AD block, data A (not last), data B (last); stray start ignored.
    do_start(0, 1'b0, 1'b0);
    start[0] = 1'b1;
    init_rounds(0, 1'b0);
    start[0] = 1'b0;
    accept(0, 1'b1);
    ad_rounds(0, 6, 1'b1);
    accept(0, 1'b0);
    data_rounds(0, 6, 1'b0, 1, 1'b0);
    accept(0, 1'b1);
    final_rounds(0, 1'b0, 2);
    check_done(0, 2);

    // dut0 decrypt with AD skipped.
    do_start(0, 1'b1, 1'b1);
    init_rounds(0, 1'b1);
    accept(0, 1'b0);
    data_rounds(0, 6, 1'b1, 1, 1'b0);
    accept(0, 1'b1);
    final_rounds(0, 1'b1, 2);
    check_done(0, 2);

    // dut0 reset in the eighth INIT round, then a clean run.
    do_start(0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check_eq("abort_ridx", 0, ridx[0], 7);
    rstn[0] = 1'b0;
    tick();
    rstn[0] = 1'b1;
    check_idle(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("abort_no_done", 0, done[0], 0);
      check_eq("abort_no_busy", 0, busy[0], 0);
    end
    do_start(0, 1'b0, 1'b1);
    init_rounds(0, 1'b1);
    accept(0, 1'b1);
    final_rounds(0, 1'b0, 1);
    check_done(0, 1);

    // dut1 sys_enable drop in the middle of an AD permutation.
    do_start(1, 1'b0, 1'b0);
    init_rounds(1, 1'b0);
    accept(1, 1'b0);
    check_eq("ad128a_first", 1, ridx[1], 4);
    tick();
    tick();
    check_eq("ad128a_mid", 1, ridx[1], 6);
    sys_en[1] = 1'b0;
    tick();
    sys_en[1] = 1'b1;
    check_idle(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("disable_no_done", 1, done[1], 0);
      check_eq("disable_no_busy", 1, busy[1], 0);
    end

    // dut1 skip_ad, five data blocks: count saturates at 3; valid held through rounds.
    do_start(1, 1'b0, 1'b1);
    init_rounds(1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      accept(1, 1'b0);
      data_rounds(1, 8, 1'b0, (k < 3) ? k : 3, (k == 1));
    end
    accept(1, 1'b1);
    final_rounds(1, 1'b0, 3);
    check_done(1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Parametrised Moore control FSM for the ASCON AEAD datapath. It is the next generation of the fixed ASCON-128 controller.
- Round counts are parameters, so one block covers ASCON-128 (12/6) and ASCON-128a (12/8).
- New versus the fixed controller: internal round and block counters, a valid/ready data handshake, variable-length associated data (AD) and data driven by a last-block flag, optional AD skip, and encrypt/decrypt mode.
- Sits between the top-level I/O wrapper and the permutation/state datapath. It drives the mux, XOR, register-enable and round-constant-index controls.

Parameters:
- ROUNDS_A, 12, rounds for initialisation and finalisation permutation p^a (legal 1..12).
- ROUNDS_B, 6, rounds for AD/data permutation p^b (legal 1..ROUNDS_A).
- BLOCK_CNT_W, 4, width of the data block counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- i_sys_enable  in  1  active-high; low forces synchronous return to IDLE
- i_start  in  1  start pulse; sampled only in IDLE
- i_decrypt  in  1  mode, latched with i_start (1 = decrypt)
- i_skip_ad  in  1  no associated data, latched with i_start
- i_data_valid  in  1  data block valid
- i_last_block  in  1  qualifies the accepted block as the last of its phase
- o_data_ready  out  1  FSM can accept a block
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle end-of-operation pulse
- o_mux_select  out  1  0 = load initial state, 1 = feedback
- o_enable_state_reg  out  1  state register enable
- o_enable_xor_data_begin  out  1  XOR data into state before the round
- o_enable_xor_key_begin  out  1  XOR key before the round (finalisation)
- o_enable_xor_key_end  out  1  XOR key after the round
- o_enable_xor_lsb_end  out  1  domain-separation XOR after the round
- o_replace_state  out  1  decrypt: overwrite the rate with ciphertext
- o_enable_cipher_reg  out  1  capture cipher/plain output
- o_valid_cipher  out  1  output block valid
- o_enable_tag_reg  out  1  capture tag
- o_round_index  out  4  round-constant index, 0..11
- o_block_count  out  BLOCK_CNT_W  data blocks accepted, saturating

Behaviour:
- Reset (reset_n=0 at a clock edge) or i_sys_enable=0:
  - state becomes IDLE; round counter, block counter and latched flags become 0.
  - All outputs are 0 except o_mux_select=1.
- Round counter:
  - Loads 12-ROUNDS_A or 12-ROUNDS_B when a phase starts, then increments once per round cycle.
  - A round is "first" when index equals the loaded value; "last" when index equals 11.
  - o_round_index presents the counter value directly.
- o_enable_state_reg=1 in every round cycle and in LOAD; 0 in IDLE, in the WAIT states and in DONE.
- Handshake:
  - A block is accepted when i_data_valid && o_data_ready.
  - o_data_ready=1 only in AD_WAIT and DATA_WAIT.
  - i_last_block is latched on acceptance.
  - Valid without ready has no effect.
- States and transitions:
  - IDLE: i_start -> LOAD; latch i_decrypt and i_skip_ad; clear the block counter.
  - LOAD (1 cycle): mux_select=0; counter <= 12-ROUNDS_A; -> INIT_ROUNDS.
  - INIT_ROUNDS (ROUNDS_A cycles): on the last round assert xor_key_end, plus xor_lsb_end if skip_ad. Then -> DATA_WAIT if skip_ad, else AD_WAIT.
  - AD_WAIT: on accept, counter <= 12-ROUNDS_B; -> AD_ROUNDS.
  - AD_ROUNDS (ROUNDS_B cycles):
    - first round: xor_data_begin.
    - last round: xor_lsb_end if last latched.
    - then -> DATA_WAIT if last, else AD_WAIT.
  - DATA_WAIT: on accept, increment the block counter (saturate at 2^BLOCK_CNT_W-1). If i_last_block, counter <= 12-ROUNDS_A and -> FINAL_ROUNDS; else counter <= 12-ROUNDS_B and -> DATA_ROUNDS.
  - DATA_ROUNDS (ROUNDS_B cycles):
    - first round: xor_data_begin, enable_cipher_reg, valid_cipher, and replace_state if decrypt.
    - last round: -> DATA_WAIT.
  - FINAL_ROUNDS (ROUNDS_A cycles):
    - first round: xor_data_begin, xor_key_begin, enable_cipher_reg, valid_cipher, and replace_state if decrypt.
    - last round: xor_key_end, enable_tag_reg; -> DONE.
  - DONE (1 cycle): o_done=1; -> IDLE.
- All end-XOR enables apply to the round computed in the same cycle.
- o_busy = (state != IDLE).
- Boundary conditions:
  - i_start outside IDLE is ignored.
  - A new i_start in the DONE cycle is ignored; restart requires an IDLE cycle.
  - Reset or i_sys_enable=0 mid-permutation aborts immediately, with no done or tag.
  - If ROUNDS_B=1, first and last round coincide and both sets of enables assert in the same cycle.
  - Undefined state encodings -> IDLE.

Test Plan:
- Defaults, i_start at cycle 0, no skip_ad: LOAD at cycle 1; INIT_ROUNDS cycles 2-13 with index 0..11; xor_key_end at cycle 13; o_data_ready=1 at cycle 14.
- One AD block (last), then data blocks A (not last) and B (last): AD rounds with index 6..11 and xor_lsb_end on index 11. Cipher valid twice. Tag enable and xor_key_end on final index 11. o_done one cycle later. o_block_count=2.
- ROUNDS_A=12, ROUNDS_B=8, skip_ad=1: xor_key_end and xor_lsb_end coincide at cycle 13; next state DATA_WAIT. Data rounds index 4..11.
- Decrypt mode: o_replace_state=1 exactly on the first round of each data/final block; 0 in encrypt mode.
- BLOCK_CNT_W=2, five data blocks: o_block_count saturates at 3. i_data_valid held high while ready=0 causes no extra accepts.
- reset_n=0 for one edge at cycle 8 of INIT_ROUNDS, or i_sys_enable low mid-AD: FSM back in IDLE next cycle, all outputs at reset values, no o_done. A later i_start completes normally.
